adc_avg_filter: RTL and testbench
=================================

# adc_avg_filter

Moving-average smoothing stage between the SPI ADC capture block and the hysteresis comparator. It takes 12-bit samples from the capture block over a valid/ack handshake and keeps a 2^DEPTH_LOG2-entry ring buffer with a running sum. It then presents the truncated mean downstream over a second valid/ack handshake. This suppresses wheel/motor noise before the forward-clearance decision.

## Interface
- DEPTH_LOG2, 3: log2 of window length N (N = 8); legal range 1..6.
- SPIKE_THRESH, 12'd400: maximum accepted |sample − current mean|. Used only with ADC_AVG_SPIKE_REJECT_EN.
- clk  input  1  system clock (25 MHz). One clock domain only.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enables acceptance of new samples; contents are retained while low.
- in_valid  input  1  sample available (capture block's ready). Level, held until acked.
- in_data  input  12  raw ADC code.
- in_ack  output  1  one-cycle pulse: sample consumed.
- out_valid  output  1  mean available. Level, held until out_ack.
- out_data  output  12  mean = sum >> DEPTH_LOG2.
- out_ack  input  1  downstream consumed out_data.
- primed  output  1  window has been filled once since reset.
- reject_pulse  output  1  one-cycle pulse: sample discarded as spike. Constant 0 without the macro.

## Operation
- Storage:
  - buf[N] of 12 bits, write pointer wp (DEPTH_LOG2 bits, wraps N−1→0).
  - sum of 12+DEPTH_LOG2 bits.
  - fill counter fc (saturates at N).
  - Reject counter rc (2 bits).
- States: IDLE, UPDATE, PUBLISH, WAIT_LOW.
- IDLE: if en & in_valid & !out_valid, latch in_data and old = buf[wp], then go to UPDATE. Otherwise stay in IDLE.
- UPDATE:
  - in_ack = 1 (this cycle only).
  - Normal path: sum ← sum + sample − old; buf[wp] ← sample; wp ← wp+1; fc ← min(fc+1, N).
  - Then go to PUBLISH.
- PUBLISH:
  - out_data ← sum >> DEPTH_LOG2.
  - If fc == N, set out_valid and primed. If not yet primed, out_valid stays 0 and the partial mean is still loaded into out_data.
  - Then go to WAIT_LOW.
- WAIT_LOW: go to IDLE once in_valid == 0. This prevents a held in_valid from being consumed twice.
- Output side: out_valid clears on the edge where out_ack is sampled high. out_ack while out_valid = 0 is ignored.
- Backpressure: while out_valid = 1, no capture occurs; in_valid simply waits.
- en low: no new capture from IDLE. A transaction already past IDLE completes normally.
- Arithmetic: the sum never overflows by construction. The mean is truncated, not rounded. Buffer entries reset to 0, so the pre-prime sum is exact.

## Timing
- Reset values:
  - in_ack = 0, out_valid = 0, out_data = 0, primed = 0, reject_pulse = 0.
  - sum = 0, wp = 0, fc = 0, rc = 0, all buf = 0, state = IDLE.
- in_valid sampled high in IDLE at edge E0 → in_ack high for the cycle E0..E1.
- out_data/out_valid updated at E2 (2-cycle latency).
- out_ack sampled at edge E → out_valid low after E. The earliest next capture is at E+1.
- Simultaneous out_ack and in_valid at the same edge: the ack is processed and the capture is not. The capture happens at the following edge.
- Throughput: at most 1 sample per 4 cycles (IDLE, UPDATE, PUBLISH, WAIT_LOW minimum).
- rst mid-transaction: all state returns to reset values at that edge, with no in_ack or out_valid emitted afterwards. An in_valid still high after reset is treated as a fresh sample.

## Configuration
- ADC_AVG_SPIKE_REJECT_EN defined: adds a spike-reject check in UPDATE.
  - Applies when primed = 1 and |sample − out_data| > SPIKE_THRESH, and rc < 3.
  - The sample is acked but not added: sum, buf, wp and fc are unchanged.
  - rc increments, reject_pulse = 1 in UPDATE, and PUBLISH re-presents the unchanged mean.
  - A 4th consecutive outlier (rc == 3) is accepted, so genuine steps are tracked.
  - rc clears on any accepted sample.
- Undefined: every sample is accepted, reject_pulse is tied to 0, and SPIKE_THRESH is unused.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 → all outputs 0, no in_ack during reset. The first in_ack follows the 1st cycle after rst falls.
- Priming: 8 samples of 12'd1000, each acked promptly → out_valid stays 0 for samples 1–7. After the 8th: out_valid = 1, out_data = 1000, primed = 1.
- Truncation/wrap: after priming, feed 0,1,…,7 → final out_data = 3 (sum 28 >> 3). wp wraps to 0.
- Backpressure: hold out_ack = 0 with in_valid = 1 → in_ack never pulses and out_data is stable. Pulsing out_ack → out_valid drops next cycle, and in_ack follows 1 cycle later.
- Held in_valid: in_valid high for 20 cycles with a single sample → exactly one in_ack pulse.
- Spike (macro on): primed at 1000, then feed 3000 ×4 → reject_pulse on samples 1–3 with out_data = 1000. The 4th is accepted: out_data = (7000+3000)>>3 = 1250. Macro off: the first 3000 gives out_data = 1250.

Source files
------------

// File: rtl/adc_avg_filter.sv
// Moving-average filter over a 2^DEPTH_LOG2 window of 12-bit ADC samples.
// It has valid/ack handshakes on both sides.
// Defining ADC_AVG_SPIKE_REJECT_EN adds outlier rejection against the current mean.
module adc_avg_filter #(
    parameter int          DEPTH_LOG2   = 3,
    parameter logic [11:0] SPIKE_THRESH = 12'd400
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        in_valid_i,
    input  logic [11:0] in_data_i,
    output logic        in_ack_o,
    output logic        out_valid_o,
    output logic [11:0] out_data_o,
    input  logic        out_ack_i,
    output logic        primed_o,
    output logic        reject_pulse_o
);

    localparam int                  N    = 1 << DEPTH_LOG2;
    localparam int                  SUMW = 12 + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(N);

    typedef enum logic [1:0] {IDLE, UPDATE, PUBLISH, WAIT_LOW} state_t;

    state_t                state_q;
    logic [11:0]           bufMem_q [N];
    logic [DEPTH_LOG2-1:0] wrPtr_q;
    logic [SUMW-1:0]       sum_q;
    logic [SUMW-1:0]       sum_d;
    logic [DEPTH_LOG2:0]   fillCnt_q;
    logic [DEPTH_LOG2:0]   fillCnt_d;
    logic [11:0]           sample_q;
    logic [11:0]           old_q;
    logic                  inAck_q;
    logic                  outValid_q;
    logic [11:0]           outData_q;
    logic                  primed_q;
    logic                  reject_q;
    logic                  spike_d;

    // Modular arithmetic is safe here: the true result always fits SUMW bits.
    always_comb begin
        sum_d     = sum_q + SUMW'(sample_q) - SUMW'(old_q);
        fillCnt_d = (fillCnt_q == FULL) ? FULL : fillCnt_q + 1'b1;
    end

`ifdef ADC_AVG_SPIKE_REJECT_EN
    logic [1:0]  rejCnt_q;
    logic [11:0] absDiff;

    // Spike decision is taken at capture so reject_pulse lines up with in_ack.
    always_comb begin
        absDiff = (in_data_i >= outData_q) ? (in_data_i - outData_q) : (outData_q - in_data_i);
        spike_d = primed_q && (absDiff > SPIKE_THRESH) && (rejCnt_q != 2'd3);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rejCnt_q <= 2'd0;
        end else if (state_q == UPDATE) begin
            rejCnt_q <= reject_q ? rejCnt_q + 2'd1 : 2'd0;
        end
    end
`else
    logic unusedSpikeThresh;

    assign spike_d           = 1'b0;
    assign unusedSpikeThresh = ^SPIKE_THRESH;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            sum_q      <= '0;
            fillCnt_q  <= '0;
            sample_q   <= '0;
            old_q      <= '0;
            inAck_q    <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            primed_q   <= 1'b0;
            reject_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bufMem_q[i] <= '0;
            end
        end else begin
            inAck_q  <= 1'b0;
            reject_q <= 1'b0;
            if (outValid_q && out_ack_i) begin
                outValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (en_i && in_valid_i && !outValid_q) begin
                        sample_q <= in_data_i;
                        old_q    <= bufMem_q[wrPtr_q];
                        inAck_q  <= 1'b1;
                        reject_q <= spike_d;
                        state_q  <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (!reject_q) begin
                        sum_q             <= sum_d;
                        bufMem_q[wrPtr_q] <= sample_q;
                        wrPtr_q           <= wrPtr_q + 1'b1;
                        fillCnt_q         <= fillCnt_d;
                    end
                    state_q <= PUBLISH;
                end
                PUBLISH: begin
                    // The partial mean is loaded even before the window is full.
                    outData_q <= sum_q[SUMW-1:DEPTH_LOG2];
                    if (fillCnt_q == FULL) begin
                        outValid_q <= 1'b1;
                        primed_q   <= 1'b1;
                    end
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!in_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ack_o       = inAck_q;
    assign out_valid_o    = outValid_q;
    assign out_data_o     = outData_q;
    assign primed_o       = primed_q;
    assign reject_pulse_o = reject_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Scoreboard bench for adc_avg_filter: stimulus pushes expected means, a negedge monitor pops and compares.
// Spike expectations follow ADC_AVG_SPIKE_REJECT_EN when it is defined.
module tb_adc_avg_filter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        inValid;
    logic [11:0] inData;
    logic        inAck;
    logic        outValid;
    logic [11:0] outData;
    logic        outAck;
    logic        primed;
    logic        rejectPulse;

    int checks    = 0;
    int failures  = 0;
    int ackCount  = 0;
    int rejCount  = 0;
    int pushCount = 0;
    int seenCount = 0;
    int expQ[$];
    bit autoAck   = 1'b1;
    bit seenCur   = 1'b0;

    adc_avg_filter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .in_valid_i    (inValid),
        .in_data_i     (inData),
        .in_ack_o      (inAck),
        .out_valid_o   (outValid),
        .out_data_o    (outData),
        .out_ack_i     (outAck),
        .primed_o      (primed),
        .reject_pulse_o(rejectPulse)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulse counters and the output-side monitor all sample on the falling edge.
    always @(negedge clk) begin
        if (inAck) ackCount++;
        if (rejectPulse) rejCount++;
    end

    always @(negedge clk) begin
        if (outValid) begin
            if (!seenCur) begin
                seenCur = 1'b1;
                seenCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected out_valid", 1, 0);
                end else begin
                    checkOutput("out_data", int'(outData), expQ.pop_front());
                end
            end
            outAck = autoAck;
        end else begin
            seenCur = 1'b0;
            outAck  = 1'b0;
        end
    end

    task automatic waitAckThenSettle(input bit alreadyAcked, input bit expValid, input int expData);
        bit got;
        got = alreadyAcked;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (inAck) got = 1'b1;
        end
        if (!got) checkOutput("in_ack timeout", 0, 1);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        if (!expValid) begin
            checkOutput("pre-prime out_valid", int'(outValid), 0);
            checkOutput("pre-prime out_data", int'(outData), expData);
        end
    endtask

    task automatic applyStimulus(input int data, input bit expValid, input int expData);
        if (expValid) begin
            expQ.push_back(expData);
            pushCount++;
        end
        inData  = 12'(data);
        inValid = 1'b1;
        waitAckThenSettle(1'b0, expValid, expData);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int r0;
        int truncExp[8] = '{875, 750, 625, 500, 376, 251, 127, 3};

        rst     = 1'b1;
        en      = 1'b1;
        inValid = 1'b1;
        inData  = 12'd1000;
        outAck  = 1'b0;

        // Reset held two cycles with in_valid high: nothing may be acked.
        repeat (2) @(negedge clk);
        checkOutput("reset in_ack count", ackCount, 0);
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset out_data", int'(outData), 0);
        checkOutput("reset primed", int'(primed), 0);
        checkOutput("reset reject_pulse", int'(rejectPulse), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first ack after reset", int'(inAck), 1);
        waitAckThenSettle(1'b1, 1'b0, 125);

        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1000, k == 8, (1000 * k) / 8);
        end
        checkOutput("primed after 8", int'(primed), 1);

        // Backpressure: a pending mean blocks further captures.
        autoAck = 1'b0;
        applyStimulus(1000, 1'b1, 1000);
        expQ.push_back(1000);
        pushCount++;
        inData  = 12'd1000;
        inValid = 1'b1;
        a0 = ackCount;
        repeat (10) @(negedge clk);
        checkOutput("backpressure no ack", ackCount - a0, 0);
        checkOutput("backpressure out_valid", int'(outValid), 1);
        checkOutput("backpressure out_data", int'(outData), 1000);
        #1 autoAck = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("out_valid dropped", int'(outValid), 0);
        checkOutput("no ack on ack edge", int'(inAck), 0);
        @(negedge clk);
        checkOutput("ack one cycle later", int'(inAck), 1);
        waitAckThenSettle(1'b1, 1'b1, 1000);

        // A single held in_valid is consumed exactly once.
        expQ.push_back(1000);
        pushCount++;
        inData  = 12'd1000;
        inValid = 1'b1;
        a0 = ackCount;
        repeat (20) @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("held in_valid acks", ackCount - a0, 1);

        // en low blocks capture until it returns.
        en = 1'b0;
        expQ.push_back(1000);
        pushCount++;
        inData  = 12'd1000;
        inValid = 1'b1;
        a0 = ackCount;
        repeat (8) @(negedge clk);
        checkOutput("en low no ack", ackCount - a0, 0);
        en = 1'b1;
        waitAckThenSettle(1'b0, 1'b1, 1000);

`ifndef ADC_AVG_SPIKE_REJECT_EN
        for (int k = 0; k < 8; k++) begin
            applyStimulus(k, 1'b1, truncExp[k]);
        end
        applyStimulus(80, 1'b1, 13);
`endif

        // Reset in the middle of a transaction: nothing further is emitted.
        inData  = 12'd1000;
        inValid = 1'b1;
        for (int i = 0; i < 60 && !inAck; i++) @(negedge clk);
        checkOutput("mid-txn ack seen", int'(inAck), 1);
        rst     = 1'b1;
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a0  = ackCount;
        repeat (5) @(negedge clk);
        checkOutput("post-reset out_valid", int'(outValid), 0);
        checkOutput("post-reset out_data", int'(outData), 0);
        checkOutput("post-reset primed", int'(primed), 0);
        checkOutput("post-reset no ack", ackCount - a0, 0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1000, k == 8, (1000 * k) / 8);
        end

        r0 = rejCount;
`ifdef ADC_AVG_SPIKE_REJECT_EN
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(3000, 1'b1, 1000);
            checkOutput("spike rejected", rejCount - r0, k);
        end
        applyStimulus(3000, 1'b1, 1250);
        checkOutput("4th outlier accepted", rejCount - r0, 3);
`else
        applyStimulus(3000, 1'b1, 1250);
        applyStimulus(3000, 1'b1, 1500);
        checkOutput("no reject without macro", rejCount - r0, 0);
`endif

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        checkOutput("outputs presented", seenCount, pushCount);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
